// File: rtl/ezm_pkg.sv
// Shared definitions for the ezm program driver.
// Contents: driver state encoding, CPU-cycle phase constants and
// the ezm instruction opcode values.
package ezm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t P0 = 2'd0;  // cpu_clk low, fetch into cpu_in
  localparam phase_t P1 = 2'd1;  // cpu_clk low, sample accumulator
  localparam phase_t P2 = 2'd2;  // cpu_clk high (CPU rising edge)
  localparam phase_t P3 = 2'd3;  // cpu_clk high, sample pc

  // Opcodes: bit 5 set = load 5-bit immediate; otherwise the top three
  // bits select the operation and the low three bits a register.
  localparam logic       OP_LOAD = 1'b1;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_BGT  = 3'b011;
  localparam logic [5:0] OP_NEG  = 6'b000001;
  localparam logic [5:0] OP_NOP  = 6'b000000;

endpackage

// File: rtl/ezm_prog_driver_if.sv
// Pin interface between the program driver (master) and the ezm CPU (slave).
//   cpu_clk  : CPU clock, generated by the driver
//   cpu_rst  : CPU synchronous reset
//   cpu_in   : 6-bit instruction bus
//   cpu_out  : 8-bit multiplexed bus, pc while cpu_clk=1, acc while cpu_clk=0
interface ezm_prog_driver_if;
  logic       cpu_clk;
  logic       cpu_rst;
  logic [5:0] cpu_in;
  logic [7:0] cpu_out;

  modport master (output cpu_clk, output cpu_rst, output cpu_in, input cpu_out);
  modport slave  (input cpu_clk, input cpu_rst, input cpu_in, output cpu_out);
endinterface

// File: rtl/ezm_prog_mem.sv
// Instruction memory: DEPTH x 6 bits, one synchronous write port,
// asynchronous read, contents not reset.
//   we/waddr/wdata : write port (clk)
//   raddr/rdata    : combinational read port
module ezm_prog_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ezm_prog_driver.sv
// Host-side driver for the ezm CPU. Loads a program into local memory,
// resets and clocks the CPU (one CPU cycle per 4 clk), feeds instructions
// by the recovered pc and reports final pc/acc when the program stops.
//   clk, rst                 : system clock, async active-high reset
//   load_valid/data/clr/ready: program loading (IDLE only)
//   start, stop_pc           : run control and halt address
//   cpu                      : CPU pin interface (master side)
//   pc_o, acc_o              : last sampled pc / accumulator
//   busy, done, timeout      : status
module ezm_prog_driver
  import ezm_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int MAX_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [5:0]           load_data,
  input  logic                 load_clr,
  output logic                 load_ready,
  input  logic                 start,
  input  logic [7:0]           stop_pc,
  ezm_prog_driver_if.master    cpu,
  output logic [7:0]           pc_o,
  output logic [7:0]           acc_o,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic          crst_cnt_q, crst_cnt_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    pc_q, pc_d, acc_q, acc_d;
  logic          timeout_q, timeout_d;
  logic          cpu_clk_q, cpu_clk_d, cpu_rst_q, cpu_rst_d;
  logic [5:0]    cpu_in_q, cpu_in_d;
  logic          mem_we, launch;
  logic [5:0]    mem_rdata;

  ezm_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (pc_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    crst_cnt_d = crst_cnt_q;
    cyc_d      = cyc_q;
    wr_ptr_d   = wr_ptr_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    timeout_d  = timeout_q;
    cpu_in_d   = cpu_in_q;
    mem_we     = 1'b0;
    launch     = start && (state_q == ST_IDLE || state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        mem_we = load_valid;
        if (load_clr)        wr_ptr_d = '0;
        else if (load_valid) wr_ptr_d = wr_ptr_q + 1'b1;
      end
      ST_CRST: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == P3) begin
          crst_cnt_d = ~crst_cnt_q;
          if (crst_cnt_q) state_d = ST_RUN;  // second CPU cycle complete
        end
      end
      ST_RUN: begin
        phase_d = phase_q + 2'd1;
        unique case (phase_q)
          P0: cpu_in_d = mem_rdata;
          P1: acc_d    = cpu.cpu_out;
          P2: cyc_d    = cyc_q + 16'd1;
          P3: begin
            pc_d = cpu.cpu_out;
            // stop_pc wins over the cycle limit, leaving timeout clear
            if (cpu.cpu_out == stop_pc) begin
              state_d = ST_DRAIN;
            end else if (cyc_q == 16'(MAX_CYC)) begin
              state_d   = ST_DRAIN;
              timeout_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_DRAIN: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == P0) cpu_in_d = OP_NOP;
        if (phase_q == P1) begin
          acc_d   = cpu.cpu_out;
          state_d = ST_DONE;
          phase_d = P0;
        end
      end
      ST_DONE: begin
        if (!start && (load_valid || load_clr)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d    = ST_CRST;
      phase_d    = P0;
      crst_cnt_d = 1'b0;
      cyc_d      = '0;
      pc_d       = '0;
      acc_d      = '0;
      timeout_d  = 1'b0;
    end

    // cpu_clk is registered from the next phase so it is high exactly in P2/P3
    cpu_rst_d = (state_d == ST_CRST);
    cpu_clk_d = (state_d == ST_CRST || state_d == ST_RUN) && phase_d[1];
    if (state_d == ST_CRST) cpu_in_d = OP_NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= P0;
      crst_cnt_q <= 1'b0;
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      pc_q       <= '0;
      acc_q      <= '0;
      timeout_q  <= 1'b0;
      cpu_clk_q  <= 1'b0;
      cpu_rst_q  <= 1'b0;
      cpu_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      crst_cnt_q <= crst_cnt_d;
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      timeout_q  <= timeout_d;
      cpu_clk_q  <= cpu_clk_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_in_q   <= cpu_in_d;
    end
  end

  assign cpu.cpu_clk = cpu_clk_q;
  assign cpu.cpu_rst = cpu_rst_q;
  assign cpu.cpu_in  = cpu_in_q;
  assign pc_o        = pc_q;
  assign acc_o       = acc_q;
  assign timeout     = timeout_q;
  assign load_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_CRST) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

endmodule
